// File: rtl/uart_rx_tx.sv
// uart_rx_tx: full-duplex 8E1 UART, fixed CLKS_PER_BIT divider.
// Define UART_PARITY_CHECK_EN to flag received parity errors.
`timescale 1ns/1ps
module uart_rx_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Parity_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
    S_PARITY, S_STOP, S_CLEANUP
  } state_t;

  state_t        tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_idx, tx_idx_nxt;
  logic [7:0]    tx_byte, tx_byte_nxt;

  // TX state and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_byte  <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_byte  <= tx_byte_nxt;
    end
  end

  // TX next state; line level decoded from state
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CW'(1);
    tx_idx_nxt   = tx_idx;
    tx_byte_nxt  = tx_byte;
    o_Tx_Serial  = 1'b1;
    o_Tx_Active  = 1'b0;
    o_Tx_Done    = 1'b0;
    unique case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt = '0;
        tx_idx_nxt = '0;
        if (i_Tx_DV) begin
          tx_byte_nxt  = i_Tx_Byte;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        o_Tx_Serial = 1'b0;
        o_Tx_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        o_Tx_Serial = tx_byte[tx_idx];
        o_Tx_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_nxt = '0;
          tx_idx_nxt = tx_idx + 3'd1;
          if (tx_idx == 3'd7)
            tx_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        o_Tx_Serial = ^tx_byte;
        o_Tx_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        o_Tx_Active = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        o_Tx_Done    = 1'b1;
        tx_cnt_nxt   = '0;
        tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  logic          rx_meta, rx_sync;
  state_t        rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]    rx_idx, rx_idx_nxt;
  logic [7:0]    rx_data, rx_data_nxt;
  logic [7:0]    rx_byte, rx_byte_nxt;
  logic          rx_dv, rx_dv_nxt;
  logic          rx_perr, rx_perr_nxt;
`ifdef UART_PARITY_CHECK_EN
  logic          rx_par, rx_par_nxt;
`endif

  // two-flop synchronizer; idles high like the line
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
      rx_perr  <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_data  <= rx_data_nxt;
      rx_byte  <= rx_byte_nxt;
      rx_dv    <= rx_dv_nxt;
      rx_perr  <= rx_perr_nxt;
`ifdef UART_PARITY_CHECK_EN
      rx_par   <= rx_par_nxt;
`endif
    end
  end

  // RX next state: mid-bit sampling after a half-bit start check
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CW'(1);
    rx_idx_nxt   = rx_idx;
    rx_data_nxt  = rx_data;
    rx_byte_nxt  = rx_byte;
    rx_dv_nxt    = 1'b0;
    rx_perr_nxt  = 1'b0;
`ifdef UART_PARITY_CHECK_EN
    rx_par_nxt   = rx_par;
`endif
    unique case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        rx_idx_nxt = '0;
        if (!rx_sync)
          rx_state_nxt = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_nxt  = '0;
          rx_data_nxt = {rx_sync, rx_data[7:1]};
          rx_idx_nxt  = rx_idx + 3'd1;
          if (rx_idx == 3'd7)
            rx_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (rx_cnt == LAST) begin
          rx_cnt_nxt   = '0;
`ifdef UART_PARITY_CHECK_EN
          rx_par_nxt   = rx_sync;
`endif
          rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = S_CLEANUP;
          if (rx_sync) begin
            rx_byte_nxt = rx_data;
            rx_dv_nxt   = 1'b1;
`ifdef UART_PARITY_CHECK_EN
            rx_perr_nxt = rx_par ^ (^rx_data);
`endif
          end
        end
      end
      S_CLEANUP: begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = S_IDLE;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  assign o_Rx_DV         = rx_dv;
  assign o_Rx_Byte       = rx_byte;
  assign o_Rx_Parity_Err = rx_perr;

endmodule

// File: tb/tb_uart_rx_tx.sv
// tb_uart_rx_tx: vector table + scoreboard bench for uart_rx_tx.
// Honours UART_PARITY_CHECK_EN for expected parity flags.
`timescale 1ns/1ps
module tb_uart_rx_tx;

  localparam int CPB    = 87;
  localparam int BIT_NS = 8600;
`ifdef UART_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       i_Clock;
  logic       i_Reset;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Parity_Err;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Tx_DV(i_Tx_DV),
    .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done(o_Tx_Done),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV(o_Rx_DV),
    .o_Rx_Byte(o_Rx_Byte),
    .o_Rx_Parity_Err(o_Rx_Parity_Err)
  );

  initial i_Clock = 1'b0;
  always #50 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;
  int dv_seen = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       p;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         gap;
    logic       exp_dv;
    logic       exp_perr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // received-byte monitor: pops the scoreboard on every DV
  logic dv_prev = 1'b0;
  always @(negedge i_Clock) begin
    sb_t e;
    if (!i_Reset && o_Rx_DV) begin
      dv_seen++;
      chk("rx_dv_width", {31'd0, dv_prev}, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_dv: got byte %0h",
                 o_Rx_Byte);
      end else begin
        e = sb.pop_front();
        chk("rx_byte", {24'd0, o_Rx_Byte}, {24'd0, e.b});
        chk("rx_perr", {31'd0, o_Rx_Parity_Err},
            {31'd0, e.p});
      end
    end
    dv_prev = o_Rx_DV && !i_Reset;
  end

  task automatic rx_frame(input logic [7:0] d,
                          input logic p,
                          input logic s,
                          input logic ep);
    if (s) sb.push_back('{b: d, p: ep});
    i_Rx_Serial = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = d[i];
      #BIT_NS;
    end
    i_Rx_Serial = p;
    #BIT_NS;
    i_Rx_Serial = s;
    #BIT_NS;
    i_Rx_Serial = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] d,
                          input bit inject);
    logic [10:0] f;
    int bad;
    f = {1'b1, ^d, d, 1'b0};
    @(negedge i_Clock);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = d;
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        if (inject && b == 3 && c == 10) begin
          i_Tx_DV   = 1'b1;
          i_Tx_Byte = ~d;
        end
        if (o_Tx_Serial !== f[b] ||
            o_Tx_Active !== 1'b1 ||
            o_Tx_Done !== 1'b0)
          bad++;
      end
      chk($sformatf("tx_%0h_bit%0d", d, b), bad, 0);
    end
    @(negedge i_Clock);
    chk("tx_done", {31'd0, o_Tx_Done}, 1);
    chk("tx_active_end", {31'd0, o_Tx_Active}, 0);
    chk("tx_idle_line", {31'd0, o_Tx_Serial}, 1);
    @(negedge i_Clock);
    chk("tx_done_once", {31'd0, o_Tx_Done}, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_tx_serial", {31'd0, o_Tx_Serial}, 1);
    chk("rst_tx_active", {31'd0, o_Tx_Active}, 0);
    chk("rst_tx_done", {31'd0, o_Tx_Done}, 0);
    chk("rst_rx_dv", {31'd0, o_Rx_DV}, 0);
    chk("rst_rx_byte", {24'd0, o_Rx_Byte}, 0);
    chk("rst_rx_perr", {31'd0, o_Rx_Parity_Err}, 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    logic [7:0] last_b;

    vecs[0] = '{8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h2F, 1'b0, 1'b1, 1, 1'b1, PCHK};
    vecs[6] = '{8'h7E, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 1, 1'b1, 1'b0};

    i_Reset     = 1'b1;
    i_Tx_DV     = 1'b0;
    i_Tx_Byte   = 8'h00;
    i_Rx_Serial = 1'b1;
    repeat (3) @(negedge i_Clock);
    check_reset_vals();
    i_Reset = 1'b0;
    repeat (5) @(negedge i_Clock);

    fork
      tx_frame(8'h2F, 1'b1);
      begin
        @(negedge i_Clock);
        #17;
        rx_frame(8'h2F, 1'b1, 1'b1, 1'b0);
        @(posedge i_Clock);
        #1;
        chk("rx_hold_2F", {24'd0, o_Rx_Byte}, 32'h2F);
      end
    join
    chk("rx_dv_count_first", dv_seen, 1);

    @(negedge i_Clock);
    #17;
    i_Rx_Serial = 1'b0;
    repeat (30) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (100) @(negedge i_Clock);
    chk("glitch_no_dv", dv_seen, 1);
    chk("glitch_byte_held", {24'd0, o_Rx_Byte}, 32'h2F);

    exp_cnt = 1;
    last_b  = 8'h2F;
    fork
      begin
        tx_frame(8'hA5, 1'b0);
        tx_frame(8'h00, 1'b0);
        tx_frame(8'hFF, 1'b0);
      end
      begin
        @(negedge i_Clock);
        #17;
        for (int i = 0; i < 8; i++) begin
          rx_frame(vecs[i].d, vecs[i].p,
                   vecs[i].s, vecs[i].exp_perr);
          if (vecs[i].exp_dv) begin
            last_b = vecs[i].d;
            exp_cnt++;
          end
          #(vecs[i].gap * BIT_NS);
          chk($sformatf("vec%0d_hold", i),
              {24'd0, o_Rx_Byte}, {24'd0, last_b});
          chk($sformatf("vec%0d_dv_count", i),
              dv_seen, exp_cnt);
        end
      end
    join

    @(negedge i_Clock);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = 8'h55;
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
    #17;
    i_Rx_Serial = 1'b0;
    #BIT_NS;
    i_Rx_Serial = 1'b1;
    #BIT_NS;
    i_Rx_Serial = 1'b0;
    #(BIT_NS / 2);
    chk("pre_rst_tx_active", {31'd0, o_Tx_Active}, 1);
    i_Reset = 1'b1;
    #10;
    check_reset_vals();
    repeat (3) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    i_Reset = 1'b0;
    repeat (5) @(negedge i_Clock);
    chk("post_rst_dv_count", dv_seen, exp_cnt);

    fork
      tx_frame(8'hC3, 1'b0);
      begin
        @(negedge i_Clock);
        #17;
        rx_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        @(posedge i_Clock);
        #1;
        chk("rx_hold_C3", {24'd0, o_Rx_Byte}, 32'hC3);
      end
    join
    chk("final_dv_count", dv_seen, exp_cnt + 1);
    repeat (10) @(negedge i_Clock);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
